// File: rtl/vx_raster_fetch_ctrl.sv
// Raster stamp fetch controller: round-robin warp arbitration, one fetch in flight.
// Optional perf counters enabled by defining RASTER_FETCH_PERF_EN.
module vx_raster_fetch_ctrl #(
   parameter int NUM_WARPS   = 4,
   parameter int NUM_THREADS = 4,
   parameter int STAMP_W     = 96,
   localparam int WID_W      = $clog2(NUM_WARPS),
   localparam int DATA_W     = NUM_THREADS * STAMP_W
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
`ifdef RASTER_FETCH_PERF_EN
   output logic [31:0]                      perf_stall_cycles_o,
   output logic [31:0]                      perf_empty_cnt_o,
`endif
   input  logic [NUM_WARPS-1:0]             fetch_req_i,
   input  logic [NUM_WARPS*NUM_THREADS-1:0] fetch_tmask_i,
   output logic [NUM_WARPS-1:0]             fetch_gnt_o,
   output logic                             rast_req_valid_o,
   input  logic                             rast_req_ready_i,
   output logic [WID_W-1:0]                 rast_req_wid_o,
   input  logic                             rast_rsp_valid_i,
   output logic                             rast_rsp_ready_o,
   input  logic                             rast_rsp_empty_i,
   input  logic [DATA_W-1:0]                rast_rsp_data_i,
   output logic                             write_enable_o,
   output logic [WID_W-1:0]                 write_wid_o,
   output logic [NUM_THREADS-1:0]           write_tmask_o,
   output logic [DATA_W-1:0]                write_data_o,
   output logic [NUM_WARPS-1:0]             done_valid_o,
   output logic                             done_empty_o
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE} state_e;

   localparam logic [NUM_WARPS-1:0] ONE = NUM_WARPS'(1);

   state_e                   state_q, state_d;
   logic [WID_W-1:0]         rr_ptr_q;
   logic [WID_W-1:0]         wid_q;
   logic [NUM_THREADS-1:0]   tmask_q;
   logic [DATA_W-1:0]        data_q;
   logic                     sel_found;
   logic [WID_W-1:0]         sel_wid;
   logic [WID_W-1:0]         cand;
   logic                     grant;
   logic                     rsp_accept;
   logic [NUM_WARPS-1:0]     gnt_d, gnt_q;
   logic                     req_valid_d, req_valid_q;
   logic                     we_d, we_q;
   logic [NUM_WARPS-1:0]     done_d, done_q;
   logic                     empty_d, empty_q;

   // Round-robin pick: scan warps starting just after the last granted one
   always_comb begin
      sel_found = 1'b0;
      sel_wid   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_WARPS; i++) begin
         cand = rr_ptr_q + WID_W'(i);
         if (!sel_found && fetch_req_i[cand]) begin
            sel_found = 1'b1;
            sel_wid   = cand;
         end
      end
   end

   assign grant      = (state_q == S_IDLE) && sel_found;
   assign rsp_accept = (state_q == S_WAIT) && rast_rsp_valid_i;

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (sel_found) state_d = S_ISSUE;
         S_ISSUE: if (rast_req_ready_i) state_d = S_WAIT;
         S_WAIT:  if (rast_rsp_valid_i)
                     state_d = rast_rsp_empty_i ? S_IDLE : S_WRITE;
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode feeding the output registers
   always_comb begin
      gnt_d       = grant ? (ONE << sel_wid) : '0;
      req_valid_d = (state_d == S_ISSUE);
      we_d        = (state_q == S_WRITE);
      empty_d     = rsp_accept && rast_rsp_empty_i;
      done_d      = (we_d || empty_d) ? (ONE << wid_q) : '0;
   end

   // Output registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         gnt_q       <= '0;
         req_valid_q <= 1'b0;
         we_q        <= 1'b0;
         done_q      <= '0;
         empty_q     <= 1'b0;
      end else begin
         gnt_q       <= gnt_d;
         req_valid_q <= req_valid_d;
         we_q        <= we_d;
         done_q      <= done_d;
         empty_q     <= empty_d;
      end
   end

   // Transaction latches: pointer/wid/tmask on grant, stamps on response
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rr_ptr_q <= WID_W'(NUM_WARPS - 1);
         wid_q    <= '0;
         tmask_q  <= '0;
         data_q   <= '0;
      end else begin
         if (grant) begin
            rr_ptr_q <= sel_wid;
            wid_q    <= sel_wid;
            tmask_q  <= fetch_tmask_i[sel_wid*NUM_THREADS +: NUM_THREADS];
         end
         if (rsp_accept && !rast_rsp_empty_i) data_q <= rast_rsp_data_i;
      end
   end

`ifdef RASTER_FETCH_PERF_EN
   logic [31:0] stall_q, empty_cnt_q;

   // Stall and empty-response counters
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_q     <= '0;
         empty_cnt_q <= '0;
      end else begin
         if ((state_q == S_ISSUE && !rast_req_ready_i) ||
             (state_q == S_WAIT && !rast_rsp_valid_i))
            stall_q <= stall_q + 32'd1;
         if (empty_d) empty_cnt_q <= empty_cnt_q + 32'd1;
      end
   end

   assign perf_stall_cycles_o = stall_q;
   assign perf_empty_cnt_o    = empty_cnt_q;
`endif

   assign fetch_gnt_o      = gnt_q;
   assign rast_req_valid_o = req_valid_q;
   assign rast_req_wid_o   = wid_q;
   assign rast_rsp_ready_o = (state_q == S_WAIT) && !reset_i;
   assign write_enable_o   = we_q;
   assign write_wid_o      = wid_q;
   assign write_tmask_o    = tmask_q;
   assign write_data_o     = data_q;
   assign done_valid_o     = done_q;
   assign done_empty_o     = empty_q;

endmodule

// File: tb/tb_vx_raster_fetch_ctrl.sv
// Scoreboard bench for vx_raster_fetch_ctrl.
// Directed transactions push expectations; a negedge monitor pops and compares.
module tb_vx_raster_fetch_ctrl;

   localparam int NW = 4;
   localparam int NT = 4;
   localparam int SW = 96;
   localparam int DW = NT * SW;

   logic            clk = 1'b0;
   logic            reset;
   logic [NW-1:0]   fetch_req;
   logic [NW*NT-1:0] fetch_tmask;
   logic [NW-1:0]   fetch_gnt;
   logic            rast_req_valid, rast_req_ready;
   logic [1:0]      rast_req_wid;
   logic            rast_rsp_valid, rast_rsp_ready, rast_rsp_empty;
   logic [DW-1:0]   rast_rsp_data;
   logic            write_enable;
   logic [1:0]      write_wid;
   logic [NT-1:0]   write_tmask;
   logic [DW-1:0]   write_data;
   logic [NW-1:0]   done_valid;
   logic            done_empty;
`ifdef RASTER_FETCH_PERF_EN
   logic [31:0]     perf_stall, perf_empty;
`endif

   vx_raster_fetch_ctrl #(.NUM_WARPS(NW), .NUM_THREADS(NT), .STAMP_W(SW)) dut (
      .clk_i(clk),
      .reset_i(reset),
`ifdef RASTER_FETCH_PERF_EN
      .perf_stall_cycles_o(perf_stall),
      .perf_empty_cnt_o(perf_empty),
`endif
      .fetch_req_i(fetch_req),
      .fetch_tmask_i(fetch_tmask),
      .fetch_gnt_o(fetch_gnt),
      .rast_req_valid_o(rast_req_valid),
      .rast_req_ready_i(rast_req_ready),
      .rast_req_wid_o(rast_req_wid),
      .rast_rsp_valid_i(rast_rsp_valid),
      .rast_rsp_ready_o(rast_rsp_ready),
      .rast_rsp_empty_i(rast_rsp_empty),
      .rast_rsp_data_i(rast_rsp_data),
      .write_enable_o(write_enable),
      .write_wid_o(write_wid),
      .write_tmask_o(write_tmask),
      .write_data_o(write_data),
      .done_valid_o(done_valid),
      .done_empty_o(done_empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    wid;
      logic [NT-1:0] tmask;
      logic [DW-1:0] data;
      int            lat;
   } wr_t;

   typedef struct {
      logic [NW-1:0] onehot;
      logic          empty;
   } dn_t;

   logic [NW-1:0] gq[$];
   wr_t           wq[$];
   dn_t           dq[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int gnt_cyc  = 0;
   bit in_flight = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pop expectations whenever the DUT presents an output
   always @(negedge clk) begin
      wr_t w;
      dn_t d;
      logic [NW-1:0] g;
      if (reset) begin
         in_flight = 0;
      end else begin
         if (done_valid != '0) begin
            if (dq.size() == 0) begin
               chk("unexpected_done", done_valid, '0);
            end else begin
               d = dq.pop_front();
               chk("done_valid", done_valid, d.onehot);
               chk("done_empty", done_empty, d.empty);
            end
            in_flight = 0;
         end
         if (write_enable) begin
            if (wq.size() == 0) begin
               chk("unexpected_write", write_enable, 1'b0);
            end else begin
               w = wq.pop_front();
               chk("write_wid", write_wid, w.wid);
               chk("write_tmask", write_tmask, w.tmask);
               chk("write_data", write_data, w.data);
               chk("write_latency", cyc - gnt_cyc, w.lat);
               chk("write_with_done", done_valid, 4'b1 << w.wid);
            end
         end
         if (fetch_gnt != '0) begin
            chk("one_in_flight", in_flight, 1'b0);
            if (gq.size() == 0) begin
               chk("unexpected_gnt", fetch_gnt, '0);
            end else begin
               g = gq.pop_front();
               chk("fetch_gnt", fetch_gnt, g);
            end
            in_flight = 1;
            gnt_cyc   = cyc;
         end
      end
   end

   task automatic chk_outputs_zero(input string nm);
      chk(nm, {fetch_gnt, rast_req_valid, rast_rsp_ready, write_enable,
               done_valid, done_empty, write_wid, write_tmask, rast_req_wid},
          '0);
      chk({nm, "_data"}, write_data, '0);
   endtask

   // One fetch: arbitration, request handshake with rd stall cycles,
   // response after vd cycles; abort asserts reset while in WAIT.
   task automatic fetch(input logic [NW-1:0] req, input logic [1:0] wid,
                        input logic [NT-1:0] tm, input int rd, input int vd,
                        input logic empty, input logic [DW-1:0] data,
                        input logic hold, input logic abort);
      wr_t w;
      dn_t d;
      logic got;
      gq.push_back(4'b1 << wid);
      if (!abort) begin
         d.onehot = 4'b1 << wid;
         d.empty  = empty;
         dq.push_back(d);
         if (!empty) begin
            w.wid = wid; w.tmask = tm; w.data = data; w.lat = 3 + rd + vd;
            wq.push_back(w);
         end
      end
      fetch_req = req;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         if (fetch_gnt != '0) got = 1'b1;
      end
      if (!got) begin
         chk("gnt_timeout", 1'b0, 1'b1);
         fetch_req = '0;
         return;
      end
      if (!hold) fetch_req = '0;
      for (int i = 0; i <= rd; i++) begin
         chk("issue_valid", rast_req_valid, 1'b1);
         chk("issue_wid", rast_req_wid, wid);
         if (i == rd) rast_req_ready = 1'b1;
         @(posedge clk); #1;
      end
      rast_req_ready = 1'b0;
      for (int i = 0; i < vd; i++) begin
         chk("wait_rsp_ready", rast_rsp_ready, 1'b1);
         @(posedge clk); #1;
      end
      if (abort) begin
         reset = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         chk_outputs_zero("abort_reset_outputs");
         reset = 1'b0;
         rast_rsp_valid = 1'b1;
         rast_rsp_data  = data;
         chk("abort_rsp_ready", rast_rsp_ready, 1'b0);
         @(posedge clk); #1;
         rast_rsp_valid = 1'b0;
         repeat (6) @(posedge clk);
         #1;
         return;
      end
      chk("rsp_ready", rast_rsp_ready, 1'b1);
      rast_rsp_valid = 1'b1;
      rast_rsp_empty = empty;
      rast_rsp_data  = data;
      @(posedge clk); #1;
      rast_rsp_valid = 1'b0;
      rast_rsp_empty = 1'b0;
   endtask

   task automatic flush;
      repeat (5) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   logic [DW-1:0] d0, d1, d2, d3;

   initial begin
      d0 = {96'h0123_4567_89ab_cdef_0011_2233, 96'h4455_6677_8899_aabb_ccdd_eeff,
            96'hdead_beef_cafe_f00d_1234_5678, 96'h9abc_def0_0fed_cba9_8765_4321};
      d1 = ~d0;
      d2 = {d0[DW/2-1:0], d0[DW-1:DW/2]};
      d3 = d0 ^ {4{96'h5555_aaaa_5555_aaaa_5555_aaaa}};
      reset          = 1'b1;
      fetch_req      = '0;
      fetch_tmask    = '0;
      rast_req_ready = 1'b0;
      rast_rsp_valid = 1'b0;
      rast_rsp_empty = 1'b0;
      rast_rsp_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero("reset_outputs");
      reset = 1'b0;
      @(posedge clk); #1;

      // Single request on warp 2
      fetch_tmask = {4'b0000, 4'b1011, 4'b0000, 4'b0000};
      fetch(4'b0100, 2'd2, 4'b1011, 0, 0, 1'b0, d0, 1'b0, 1'b0);
      flush();

      // Empty response on warp 1
      fetch_tmask = {4'b0000, 4'b0000, 4'b0110, 4'b0000};
      fetch(4'b0010, 2'd1, 4'b0110, 0, 0, 1'b1, d1, 1'b0, 1'b0);
      flush();
`ifdef RASTER_FETCH_PERF_EN
      chk("perf_empty_cnt", perf_empty, 32'd1);
      chk("perf_stall_zero", perf_stall, 32'd0);
`endif

      // Backpressure on warp 3
      fetch_tmask = {4'b1001, 4'b0000, 4'b0000, 4'b0000};
      fetch(4'b1000, 2'd3, 4'b1001, 5, 3, 1'b0, d2, 1'b0, 1'b0);
      flush();
`ifdef RASTER_FETCH_PERF_EN
      chk("perf_stall_cycles", perf_stall, 32'd8);
`endif

      // Fairness with all requests held; warp 1 has an all-zero mask
      fetch_tmask = {4'b1100, 4'b0101, 4'b0000, 4'b1111};
      fetch(4'b1111, 2'd0, 4'b1111, 0, 0, 1'b0, d0, 1'b1, 1'b0);
      fetch(4'b1111, 2'd1, 4'b0000, 0, 0, 1'b0, d1, 1'b1, 1'b0);
      fetch(4'b1111, 2'd2, 4'b0101, 0, 0, 1'b0, d2, 1'b1, 1'b0);
      fetch(4'b1111, 2'd3, 4'b1100, 0, 0, 1'b0, d3, 1'b1, 1'b0);
      fetch(4'b1111, 2'd0, 4'b1111, 0, 0, 1'b0, d1, 1'b0, 1'b0);
      flush();

      // Reset while waiting for the response, then a fresh request
      fetch_tmask = {4'b0000, 4'b0000, 4'b1110, 4'b0111};
      fetch(4'b0010, 2'd1, 4'b1110, 0, 1, 1'b0, d3, 1'b0, 1'b1);
      fetch(4'b0001, 2'd0, 4'b0111, 0, 0, 1'b0, d2, 1'b0, 1'b0);
      flush();

      chk("gnt_queue_drained", gq.size(), 0);
      chk("write_queue_drained", wq.size(), 0);
      chk("done_queue_drained", dq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
